// File: rtl/fir_pkg.sv
// fir_pkg: state encoding and default widths for the FIR coefficient sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int TAPS_DEF    = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int COEFF_W_DEF = 8;
    localparam int ACC_W_DEF   = 20;
    localparam int OUT_W_DEF   = 16;

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: TAPS-deep sample history. x[0] is the newest sample;
// a shift pushes din in at x[0] and drops x[TAPS-1]. tap returns x[sel].
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic signed [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0]        sel,
    output logic signed [DATA_W-1:0] tap
);

    logic signed [DATA_W-1:0] r_x [TAPS];

    // shift the history by one on each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
        end else if (shift_en) begin
            r_x[0] <= din;
            for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
        end
    end

    // tap select; addresses beyond the last tap read as zero
    always_comb begin
        tap = '0;
        if (int'(sel) < TAPS) tap = r_x[sel];
    end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: time-multiplexed FIR, one MAC per clock over TAPS
// coefficients read from a 1-cycle-latency synchronous ROM.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_coeff_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = TAPS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = 0
)(
    input  logic                      clka,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [ADDR_W-1:0]         rom_addra,
    input  logic [COEFF_W-1:0]        rom_douta,
    output logic signed [OUT_W-1:0]   dout,
    output logic                      dout_valid,
    output logic                      busy
);

    localparam int                PROD_W    = DATA_W + COEFF_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);

    state_t                    r_state, w_next;
    logic                      w_accept;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W-1:0]         r_prd_idx;
    logic                      r_prd_vld;
    logic signed [DATA_W-1:0]  w_tap;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [OUT_W-1:0]   w_narrow;
    logic signed [OUT_W-1:0]   r_dout;

    assign w_accept  = din_valid && din_ready;
    assign rom_addra = r_addr;

    // state register
    always_ff @(posedge clka or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state and handshake outputs. OUT presents the result and is also
    // ready for the next sample, so a back-to-back pass starts every TAPS+2 cycles.
    always_comb begin
        w_next     = r_state;
        din_ready  = 1'b0;
        busy       = 1'b0;
        dout_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) w_next = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy   = 1'b1;
                w_next = S_OUT;
            end
            S_OUT: begin
                dout_valid = 1'b1;
                din_ready  = 1'b1;
                w_next     = din_valid ? S_MAC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // address walk: counts up while in MAC, parks at the last tap, clears outside MAC
    always_ff @(posedge clka or posedge rst) begin
        if (rst)                                           r_addr <= '0;
        else if (r_state == S_MAC && r_addr != LAST_ADDR)  r_addr <= r_addr + 1'b1;
        else if (r_state != S_MAC)                         r_addr <= '0;
    end

    // align the tap index with the ROM word returning one cycle after its address
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_prd_vld <= 1'b0;
            r_prd_idx <= '0;
        end else begin
            r_prd_vld <= (r_state == S_MAC);
            r_prd_idx <= r_addr;
        end
    end

    fir_delay_line #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dly (
        .clk      (clka),
        .rst      (rst),
        .shift_en (w_accept),
        .din      (din),
        .sel      (r_prd_idx),
        .tap      (w_tap)
    );

    // full-width signed product, sign-extended into the accumulator
    assign w_prod     = PROD_W'(w_tap) * PROD_W'($signed(rom_douta));
    assign w_prod_ext = ACC_W'(w_prod);

    // accumulator: cleared on accept, one MAC per returned coefficient
    always_ff @(posedge clka or posedge rst) begin
        if (rst)            r_acc <= '0;
        else if (w_accept)  r_acc <= '0;
        else if (r_prd_vld) r_acc <= r_acc + w_prod_ext;
    end

    assign w_shifted = r_acc >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    // clamp to the output range
    always_comb begin
        if (w_shifted > SAT_MAX)      w_narrow = SAT_MAX[OUT_W-1:0];
        else if (w_shifted < SAT_MIN) w_narrow = SAT_MIN[OUT_W-1:0];
        else                          w_narrow = w_shifted[OUT_W-1:0];
    end
`else
    assign w_narrow = w_shifted[OUT_W-1:0];
`endif

    // hold the last result between passes
    always_ff @(posedge clka or posedge rst) begin
        if (rst)                  r_dout <= '0;
        else if (r_state == S_OUT) r_dout <= w_narrow;
    end

    // the fresh result is visible in the same cycle as dout_valid
    assign dout = (r_state == S_OUT) ? w_narrow : r_dout;

endmodule
